// File: rtl/uart_ctrl_fifo.sv
// uart_ctrl_fifo: XT_BUS UART peripheral with TX/RX FIFOs in a single clock domain.
//   hb_clk / hb_rst : bus clock and synchronous active-high reset
//   xt_hb / sel     : bus request (raddr, waddr, wdata) and slave select (ren, wen)
//   rdata           : registered read data, holds between reads
//   rx_irq / tx_irq : registered level interrupts (RX data available, TX drained)
//   uart_rx         : asynchronous serial input
//   uart_tx         : serial output, idles high
// Registers (addr[4:0]): 0x10 BAUD_DIV, 0x14 CTRL, 0x18 STATUS, 0x1C DATA.
package xt_bus_pkg;
    typedef struct packed {
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } hb_slave_t;

    typedef struct packed {
        logic ren;
        logic wen;
    } sel_t;
endpackage

module uart_ctrl_fifo
    import xt_bus_pkg::*;
#(
    parameter int OVER_SAMPLING = 16,
    parameter int DATA_BITS     = 8,
    parameter int RX_DEPTH      = 8,
    parameter int TX_DEPTH      = 8,
    parameter int DIV_WIDTH     = 16,
    parameter int DEFAULT_DIV   = 0
) (
    input  logic        hb_clk,
    input  logic        hb_rst,
    input  hb_slave_t   xt_hb,
    input  sel_t        sel,
    output logic [31:0] rdata,
    output logic        rx_irq,
    output logic        tx_irq,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = $clog2(RX_DEPTH + 1);
    localparam int TX_CW = $clog2(TX_DEPTH + 1);
    localparam int OS_W  = $clog2(OVER_SAMPLING);

    localparam logic [OS_W-1:0] BIT_LAST = OS_W'(OVER_SAMPLING - 1);
    localparam logic [OS_W-1:0] MID_1    = OS_W'(OVER_SAMPLING / 2 - 1);
    localparam logic [OS_W-1:0] MID_2    = OS_W'(OVER_SAMPLING / 2);
    localparam logic [OS_W-1:0] MID_3    = OS_W'(OVER_SAMPLING / 2 + 1);
    localparam logic [2:0]      IDX_LAST = 3'(DATA_BITS - 1);

    localparam logic [4:0] A_BAUD = 5'h10;
    localparam logic [4:0] A_CTRL = 5'h14;
    localparam logic [4:0] A_STAT = 5'h18;
    localparam logic [4:0] A_DATA = 5'h1C;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Only the low address bits and the low data bits are decoded.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{xt_hb.raddr, xt_hb.waddr, xt_hb.wdata};

    logic wr_baud, wr_ctrl, wr_stat, wr_data, rd_data;
    assign wr_baud = sel.wen && (xt_hb.waddr[4:0] == A_BAUD);
    assign wr_ctrl = sel.wen && (xt_hb.waddr[4:0] == A_CTRL);
    assign wr_stat = sel.wen && (xt_hb.waddr[4:0] == A_STAT);
    assign wr_data = sel.wen && (xt_hb.waddr[4:0] == A_DATA);
    assign rd_data = sel.ren && (xt_hb.raddr[4:0] == A_DATA);

    logic [DIV_WIDTH-1:0] baud_div_reg, div_active_reg, div_cnt_reg;
    logic [4:0]           ctrl_reg;
    logic                 tick;
    logic [2:0]           tx_state_reg, rx_state_reg;

    // Divisor used by the tick counter only follows BAUD_DIV while no frame is in
    // flight, so a frame keeps a constant bit time.
    assign tick = (div_cnt_reg >= div_active_reg);

    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            baud_div_reg   <= DIV_WIDTH'(DEFAULT_DIV);
            div_active_reg <= DIV_WIDTH'(DEFAULT_DIV);
            div_cnt_reg    <= '0;
            ctrl_reg       <= '0;
        end else begin
            if (wr_baud) baud_div_reg <= xt_hb.wdata[DIV_WIDTH-1:0];
            if (wr_ctrl) ctrl_reg <= xt_hb.wdata[4:0];
            if (tx_state_reg == S_IDLE && rx_state_reg == S_IDLE)
                div_active_reg <= baud_div_reg;
            if (wr_baud || tick) div_cnt_reg <= '0;
            else                 div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]     tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [TX_CW-1:0]     tx_count_reg;
    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_full  = (tx_count_reg == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_count_reg == '0);
    assign tx_push  = wr_data && (!tx_full || tx_pop);
    assign tx_head  = tx_mem[tx_rd_ptr_reg];

    always_ff @(posedge hb_clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_reg] <= xt_hb.wdata[DATA_BITS-1:0];
    end

    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            if (tx_push && !tx_pop)      tx_count_reg <= tx_count_reg + 1'b1;
            else if (!tx_push && tx_pop) tx_count_reg <= tx_count_reg - 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    logic [OS_W-1:0]      tx_tick_cnt_reg;
    logic [2:0]           tx_idx_reg;
    logic [DATA_BITS-1:0] tx_shift_reg;
    logic                 tx_par_reg, tx_par_en_reg, tx_stop2_reg, tx_stop_cnt_reg, tx_line_reg;
    logic                 tx_bit_end, tx_idle;

    assign tx_bit_end = tick && (tx_tick_cnt_reg == BIT_LAST);
    assign tx_idle    = (tx_state_reg == S_IDLE) && tx_empty;
    // A new frame starts from IDLE on any tick, or straight out of the final stop bit.
    assign tx_pop = tick && !tx_empty &&
                    ((tx_state_reg == S_IDLE) ||
                     (tx_state_reg == S_STOP && tx_bit_end && (!tx_stop2_reg || tx_stop_cnt_reg)));
    assign uart_tx = tx_line_reg;

    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            tx_state_reg    <= S_IDLE;
            tx_tick_cnt_reg <= '0;
            tx_idx_reg      <= '0;
            tx_shift_reg    <= '0;
            tx_par_reg      <= 1'b0;
            tx_par_en_reg   <= 1'b0;
            tx_stop2_reg    <= 1'b0;
            tx_stop_cnt_reg <= 1'b0;
            tx_line_reg     <= 1'b1;
        end else begin
            if (tx_state_reg != S_IDLE && tick)
                tx_tick_cnt_reg <= tx_bit_end ? '0 : tx_tick_cnt_reg + 1'b1;
            if (tx_pop) begin
                tx_state_reg    <= S_START;
                tx_line_reg     <= 1'b0;
                tx_shift_reg    <= tx_head;
                tx_par_reg      <= (^tx_head) ^ ctrl_reg[1];
                tx_par_en_reg   <= ctrl_reg[0];
                tx_stop2_reg    <= ctrl_reg[2];
                tx_stop_cnt_reg <= 1'b0;
                tx_tick_cnt_reg <= '0;
            end else if (tx_bit_end) begin
                case (tx_state_reg)
                    S_START: begin
                        tx_state_reg <= S_DATA;
                        tx_line_reg  <= tx_shift_reg[0];
                        tx_idx_reg   <= '0;
                    end
                    S_DATA: begin
                        if (tx_idx_reg == IDX_LAST) begin
                            tx_state_reg <= tx_par_en_reg ? S_PARITY : S_STOP;
                            tx_line_reg  <= tx_par_en_reg ? tx_par_reg : 1'b1;
                        end else begin
                            tx_idx_reg   <= tx_idx_reg + 1'b1;
                            tx_shift_reg <= tx_shift_reg >> 1;
                            tx_line_reg  <= tx_shift_reg[1];
                        end
                    end
                    S_PARITY: begin
                        tx_state_reg <= S_STOP;
                        tx_line_reg  <= 1'b1;
                    end
                    S_STOP: begin
                        if (tx_stop2_reg && !tx_stop_cnt_reg) tx_stop_cnt_reg <= 1'b1;
                        else                                   tx_state_reg    <= S_IDLE;
                    end
                    default: tx_state_reg <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- RX FSM ----------------
    logic                 rx_s1_reg, rx_s2_reg, rx_prev_reg;
    logic [OS_W-1:0]      rx_tick_cnt_reg;
    logic [2:0]           rx_idx_reg;
    logic [DATA_BITS-1:0] rx_shift_reg;
    logic [1:0]           rx_ones_reg, rx_ones_total;
    logic                 rx_par_en_reg, rx_par_odd_reg;
    logic                 rx_fall, rx_mid3, rx_bit_end, rx_vote, rx_done;

    assign rx_fall       = rx_prev_reg && !rx_s2_reg;
    assign rx_mid3       = tick && (rx_tick_cnt_reg == MID_3);
    assign rx_bit_end    = tick && (rx_tick_cnt_reg == BIT_LAST);
    // Majority of three: two samples accumulated, the third is the live one.
    assign rx_ones_total = rx_ones_reg + {1'b0, rx_s2_reg};
    assign rx_vote       = rx_ones_total[1];
    assign rx_done       = (rx_state_reg == S_STOP) && rx_mid3;

    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            rx_s1_reg       <= 1'b1;
            rx_s2_reg       <= 1'b1;
            rx_prev_reg     <= 1'b1;
            rx_state_reg    <= S_IDLE;
            rx_tick_cnt_reg <= '0;
            rx_idx_reg      <= '0;
            rx_shift_reg    <= '0;
            rx_ones_reg     <= '0;
            rx_par_en_reg   <= 1'b0;
            rx_par_odd_reg  <= 1'b0;
        end else begin
            rx_s1_reg   <= uart_rx;
            rx_s2_reg   <= rx_s1_reg;
            rx_prev_reg <= rx_s2_reg;
            if (rx_state_reg != S_IDLE && tick) begin
                rx_tick_cnt_reg <= rx_bit_end ? '0 : rx_tick_cnt_reg + 1'b1;
                if (rx_tick_cnt_reg == MID_1) rx_ones_reg <= {1'b0, rx_s2_reg};
                if (rx_tick_cnt_reg == MID_2) rx_ones_reg <= rx_ones_total;
            end
            case (rx_state_reg)
                S_IDLE: if (rx_fall) begin
                    rx_state_reg    <= S_START;
                    rx_tick_cnt_reg <= '0;
                    rx_par_en_reg   <= ctrl_reg[0];
                    rx_par_odd_reg  <= ctrl_reg[1];
                end
                S_START: begin
                    if (rx_mid3 && rx_vote) rx_state_reg <= S_IDLE;
                    else if (rx_bit_end) begin
                        rx_state_reg <= S_DATA;
                        rx_idx_reg   <= '0;
                    end
                end
                S_DATA: begin
                    if (rx_mid3) rx_shift_reg <= {rx_vote, rx_shift_reg[DATA_BITS-1:1]};
                    if (rx_bit_end) begin
                        if (rx_idx_reg == IDX_LAST) rx_state_reg <= rx_par_en_reg ? S_PARITY : S_STOP;
                        else                        rx_idx_reg   <= rx_idx_reg + 1'b1;
                    end
                end
                S_PARITY: if (rx_bit_end) rx_state_reg <= S_STOP;
                // Return to IDLE mid-stop so a back-to-back start edge is not missed.
                S_STOP:   if (rx_mid3) rx_state_reg <= S_IDLE;
                default:  rx_state_reg <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]     rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [RX_CW-1:0]     rx_count_reg;
    logic                 rx_full, rx_empty, rx_push, rx_pop;

    assign rx_full  = (rx_count_reg == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count_reg == '0);
    assign rx_pop   = rd_data && !rx_empty;
    assign rx_push  = rx_done && (!rx_full || rx_pop);

    always_ff @(posedge hb_clk) begin
        if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_shift_reg;
    end

    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            if (rx_push && !rx_pop)      rx_count_reg <= rx_count_reg + 1'b1;
            else if (!rx_push && rx_pop) rx_count_reg <= rx_count_reg - 1'b1;
        end
    end

    // ---------------- Error flags, interrupts, read data ----------------
    logic overrun_reg, par_err_reg, frame_err_reg;
    logic overrun_set, par_err_set, frame_err_set;
    logic [31:0] status_word;

    assign overrun_set   = rx_done && rx_full && !rx_pop;
    assign par_err_set   = (rx_state_reg == S_PARITY) && rx_mid3 &&
                           (rx_vote != ((^rx_shift_reg) ^ rx_par_odd_reg));
    assign frame_err_set = rx_done && !rx_vote;
    assign status_word   = {16'd0, 8'(rx_count_reg), 1'b0, frame_err_reg, par_err_reg,
                            overrun_reg, rx_full, rx_empty, tx_full, tx_idle};

    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            overrun_reg   <= 1'b0;
            par_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            rx_irq        <= 1'b0;
            tx_irq        <= 1'b0;
            rdata         <= '0;
        end else begin
            // A same-cycle set wins over write-1-to-clear.
            overrun_reg   <= overrun_set   | (overrun_reg   & ~(wr_stat & xt_hb.wdata[4]));
            par_err_reg   <= par_err_set   | (par_err_reg   & ~(wr_stat & xt_hb.wdata[5]));
            frame_err_reg <= frame_err_set | (frame_err_reg & ~(wr_stat & xt_hb.wdata[6]));
            rx_irq        <= ctrl_reg[3] & !rx_empty;
            tx_irq        <= ctrl_reg[4] & tx_idle;
            if (sel.ren) begin
                case (xt_hb.raddr[4:0])
                    A_BAUD:  rdata <= 32'(baud_div_reg);
                    A_CTRL:  rdata <= 32'(ctrl_reg);
                    A_STAT:  rdata <= status_word;
                    A_DATA:  rdata <= rx_empty ? 32'd0 : 32'(rx_mem[rx_rd_ptr_reg]);
                    default: rdata <= 32'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_ctrl_fifo.sv
// tb_uart_ctrl_fifo: self-checking bench for uart_ctrl_fifo (default parameters).
// Expected TX line bits and expected RX bytes are queued when stimulus is driven
// and compared when the DUT produces them.
module tb_uart_ctrl_fifo;
    import xt_bus_pkg::*;

    logic        hb_clk = 1'b0;
    logic        hb_rst;
    hb_slave_t   xt_hb;
    sel_t        sel;
    logic [31:0] rdata;
    logic        rx_irq, tx_irq, uart_rx, uart_tx;
    logic        rx_drive, loop_en;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q [$];
    bit         tx_q [$];

    localparam logic [4:0] A_BAUD = 5'h10;
    localparam logic [4:0] A_CTRL = 5'h14;
    localparam logic [4:0] A_STAT = 5'h18;
    localparam logic [4:0] A_DATA = 5'h1C;

    assign uart_rx = loop_en ? uart_tx : rx_drive;

    always #5 hb_clk = ~hb_clk;

    uart_ctrl_fifo dut (
        .hb_clk  (hb_clk),
        .hb_rst  (hb_rst),
        .xt_hb   (xt_hb),
        .sel     (sel),
        .rdata   (rdata),
        .rx_irq  (rx_irq),
        .tx_irq  (tx_irq),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("chk  %s = 0x%0h", tag, got);
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge hb_clk);
        xt_hb.waddr = {27'd0, a};
        xt_hb.wdata = d;
        sel.wen     = 1'b1;
        @(negedge hb_clk);
        sel.wen     = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge hb_clk);
        xt_hb.raddr = {27'd0, a};
        sel.ren     = 1'b1;
        @(negedge hb_clk);
        sel.ren     = 1'b0;
        d           = rdata;
    endtask

    // Queue the expected line levels of one frame.
    task automatic tx_expect(input logic [7:0] b, input bit pen, input bit podd, input int nstop);
        tx_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) tx_q.push_back(b[k]);
        if (pen) tx_q.push_back((^b) ^ podd);
        for (int k = 0; k < nstop; k++) tx_q.push_back(1'b1);
    endtask

    // Wait for a start edge, then sample uart_tx in the middle of every bit.
    task automatic tx_capture(input int cpb, input string tag);
        int  n;
        bit  b;
        n = 0;
        while (uart_tx !== 1'b0 && n < 400) begin
            @(negedge hb_clk);
            n++;
        end
        if (n >= 400) begin
            chk({tag, "_start_timeout"}, 32'(uart_tx), 32'd0);
            tx_q.delete();
            return;
        end
        repeat (cpb / 2) @(negedge hb_clk);
        while (tx_q.size() > 0) begin
            b = tx_q.pop_front();
            chk(tag, 32'(uart_tx), 32'(b));
            if (tx_q.size() > 0) repeat (cpb) @(negedge hb_clk);
        end
    endtask

    task automatic rx_bit(input bit v, input int cpb);
        rx_drive = v;
        repeat (cpb) @(negedge hb_clk);
    endtask

    task automatic rx_send(input logic [7:0] b, input bit pen, input bit podd, input bit stop_low);
        rx_bit(1'b0, 16);
        for (int k = 0; k < 8; k++) rx_bit(b[k], 16);
        if (pen) rx_bit((^b) ^ podd, 16);
        rx_bit(!stop_low, 16);
        rx_bit(1'b1, 32);
    endtask

    task automatic wait_rx_count(input int n, input int polls);
        logic [31:0] st;
        int          p;
        p = 0;
        st = '0;
        while (p < polls) begin
            bus_rd(A_STAT, st);
            if (st[15:8] == 8'(n)) break;
            p++;
        end
        chk("rx_count_reached", 32'(st[15:8]), 32'(n));
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;

        hb_rst   = 1'b1;
        xt_hb    = '0;
        sel      = '0;
        rx_drive = 1'b1;
        loop_en  = 1'b0;
        repeat (3) @(negedge hb_clk);
        hb_rst = 1'b0;

        // Reset state
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rx_irq", 32'(rx_irq), 32'd0);
        chk("rst_tx_irq", 32'(tx_irq), 32'd0);
        bus_rd(A_STAT, d); chk("rst_status", d, 32'h05);
        bus_rd(A_DATA, d); chk("empty_data_rd", d, 32'h0);
        bus_rd(A_STAT, d); chk("status_again", d, 32'h05);
        bus_rd(5'h04, d);  chk("unmapped_rd", d, 32'h0);
        bus_rd(A_CTRL, d); chk("rst_ctrl", d, 32'h0);
        bus_rd(A_BAUD, d); chk("rst_baud", d, 32'h0);

        // TX 0xA5, 8N1, DIV=0: 16 clocks per bit
        bus_wr(A_CTRL, 32'h10);
        repeat (3) @(negedge hb_clk);
        chk("tx_irq_idle", 32'(tx_irq), 32'd1);
        tx_expect(8'hA5, 1'b0, 1'b0, 1);
        bus_wr(A_DATA, 32'hA5);
        tx_capture(16, "tx_a5_bit");
        chk("tx_irq_busy", 32'(tx_irq), 32'd0);
        repeat (12) @(negedge hb_clk);
        chk("tx_irq_after_stop", 32'(tx_irq), 32'd1);

        // TX 0x3C with DIV=1: 32 clocks per bit
        bus_wr(A_BAUD, 32'd1);
        bus_rd(A_BAUD, d); chk("baud_rb", d, 32'd1);
        tx_expect(8'h3C, 1'b0, 1'b0, 1);
        bus_wr(A_DATA, 32'h3C);
        tx_capture(32, "tx_div1_bit");
        repeat (40) @(negedge hb_clk);
        bus_wr(A_BAUD, 32'd0);
        repeat (4) @(negedge hb_clk);

        // Loopback, odd parity, two stop bits, rx interrupt enabled
        bus_wr(A_CTRL, 32'h0F);
        loop_en = 1'b1;
        foreach (rx_q[i]) rx_q.delete(i);
        rx_q.push_back(8'h00); bus_wr(A_DATA, 32'h00);
        rx_q.push_back(8'hFF); bus_wr(A_DATA, 32'hFF);
        rx_q.push_back(8'h3C); bus_wr(A_DATA, 32'h3C);
        wait_rx_count(3, 600);
        chk("rx_irq_set", 32'(rx_irq), 32'd1);
        bus_rd(A_STAT, d); chk("loop_errors", 32'(d[6:4]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus_rd(A_DATA, d);
            b = rx_q.pop_front();
            chk("loop_byte", d, 32'(b));
            bus_rd(A_STAT, d);
            chk("loop_rx_count", 32'(d[15:8]), 32'(2 - i));
        end
        repeat (2) @(negedge hb_clk);
        chk("rx_irq_clear", 32'(rx_irq), 32'd0);
        repeat (60) @(negedge hb_clk);
        loop_en = 1'b0;

        // Frame error: 0x55 with stop bit low, 8N1
        bus_wr(A_CTRL, 32'h00);
        rx_send(8'h55, 1'b0, 1'b0, 1'b1);
        bus_rd(A_STAT, d); chk("frame_err_set", 32'(d[6]), 32'd1);
        bus_rd(A_DATA, d); chk("frame_err_byte", d, 32'h55);
        bus_wr(A_STAT, 32'h40);
        bus_rd(A_STAT, d); chk("frame_err_clr", 32'(d[6]), 32'd0);

        // Overrun: RX_DEPTH+1 frames with no reads
        for (int i = 0; i < 9; i++) begin
            b = 8'(i * 29 + 7);
            if (i < 8) rx_q.push_back(b);
            rx_send(b, 1'b0, 1'b0, 1'b0);
        end
        bus_rd(A_STAT, d);
        chk("ovr_rx_full", 32'(d[3]), 32'd1);
        chk("ovr_flag", 32'(d[4]), 32'd1);
        chk("ovr_count", 32'(d[15:8]), 32'd8);
        for (int i = 0; i < 8; i++) begin
            bus_rd(A_DATA, d);
            b = rx_q.pop_front();
            chk("ovr_byte", d, 32'(b));
        end
        bus_wr(A_STAT, 32'h10);
        bus_rd(A_STAT, d); chk("ovr_cleared_status", d, 32'h05);

        // Four-tick low glitch: nothing stored, receiver still works afterwards
        rx_drive = 1'b0;
        repeat (4) @(negedge hb_clk);
        rx_drive = 1'b1;
        repeat (40) @(negedge hb_clk);
        bus_rd(A_STAT, d); chk("glitch_status", d, 32'h05);
        rx_q.push_back(8'h96);
        rx_send(8'h96, 1'b0, 1'b0, 1'b0);
        bus_rd(A_DATA, d);
        b = rx_q.pop_front();
        chk("post_glitch_byte", d, 32'(b));

        // Reset in the middle of a TX data bit
        bus_wr(A_DATA, 32'h00);
        bus_wr(A_DATA, 32'h00);
        d = 0;
        while (uart_tx !== 1'b0 && d < 100) begin
            @(negedge hb_clk);
            d++;
        end
        repeat (36) @(negedge hb_clk);
        chk("pre_rst_tx_data", 32'(uart_tx), 32'd0);
        hb_rst = 1'b1;
        @(negedge hb_clk);
        chk("rst_mid_tx_line", 32'(uart_tx), 32'd1);
        hb_rst = 1'b0;
        bus_rd(A_STAT, d); chk("rst_mid_tx_status", d, 32'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
